jk_ff_bank: RTL and testbench

JK_FF_BANK -- requirements
Module: jk_ff_bank

---
 rtl/jk_ff_bank.sv | 110 +++++++++++
 tb/tb_jk_ff_bank.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: a bank of WIDTH independent flip-flop channels. A 2-bit mode
// selects JK, D, T or SR behaviour for every channel at once.
// All state is registered on the rising edge of clk. Reset is synchronous
// and active-high.
// Optional feature: define JK_FF_BANK_TOGGLE_CNT_EN to build a saturating
// count of edges that altered q. Without it, toggle_cnt is tied to 0.

// Per-channel next-state logic. This block holds no state; the bank keeps
// the registers.
module jk_ff_lane (
  input  logic [1:0] mode,
  input  logic       j,
  input  logic       k,
  input  logic       q,
  output logic       q_nxt,
  output logic       sr_ill
);
  localparam logic [1:0] M_JK = 2'b00;
  localparam logic [1:0] M_D  = 2'b01;
  localparam logic [1:0] M_T  = 2'b10;

  // Select the next state for this channel from the current mode.
  always_comb begin
    q_nxt  = q;
    sr_ill = 1'b0;
    case (mode)
      M_JK:    q_nxt = (j & ~q) | (~k & q);
      M_D:     q_nxt = j;
      M_T:     q_nxt = q ^ j;
      default: begin
        // In SR mode, S=R=1 is illegal. The bit holds and the error is flagged.
        sr_ill = j & k;
        if (j & ~k)      q_nxt = 1'b1;
        else if (~j & k) q_nxt = 1'b0;
      end
    endcase
  end
endmodule

module jk_ff_bank #(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             changed,
  output logic             sr_err,
  output logic [CNT_W-1:0] toggle_cnt
);
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] sr_ill;
  logic             diff;
  logic             sr_hit;

  // Each channel has its own next-state slice.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    jk_ff_lane u_lane (
      .mode   (mode),
      .j      (j[i]),
      .k      (k[i]),
      .q      (q[i]),
      .q_nxt  (q_nxt[i]),
      .sr_ill (sr_ill[i])
    );
  end

  assign diff   = en & (q_nxt != q);
  assign sr_hit = en & (|sr_ill);
  assign q_n    = ~q;

  // Channel state and the one-cycle changed flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= RST_VAL;
      changed <= 1'b0;
    end else begin
      if (en) q <= q_nxt;
      changed <= diff;
    end
  end

  // Sticky SR error. A fresh error wins over clr_err. The clear also works while en=0.
  always_ff @(posedge clk) begin
    if (reset)        sr_err <= 1'b0;
    else if (sr_hit)  sr_err <= 1'b1;
    else if (clr_err) sr_err <= 1'b0;
  end

`ifdef JK_FF_BANK_TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Count edges that altered q. The counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset)                     cnt_r <= '0;
    else if (diff && !(&cnt_r))    cnt_r <= cnt_r + 1'b1;
  end

  assign toggle_cnt = cnt_r;
`else
  assign toggle_cnt = '0;
`endif
endmodule

// File: tb/tb_jk_ff_bank.sv
// Self-checking bench for jk_ff_bank. The bench models the expected outputs
// and queues them when it drives an edge. It pops and compares them one
// time unit after that edge. A second instance with CNT_W=2 shares the
// same stimulus so that counter saturation gets exercised.
module tb_jk_ff_bank;
  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j, k;
  logic       clr_err;
  logic [7:0] q, q_n, q2, q2_n;
  logic       changed, sr_err, changed2, sr_err2;
  logic [15:0] toggle_cnt;
  logic [1:0]  toggle_cnt2;

  typedef struct {
    logic [7:0]  q;
    logic        chg;
    logic        err;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t exp_q[$];

  // Model state
  logic [7:0]  mq;
  logic        merr;
  logic [15:0] mcnt;
  logic [1:0]  mcnt2;

  int n_chk  = 0;
  int n_pass = 0;

  jk_ff_bank #(.WIDTH(8), .CNT_W(16), .RST_VAL(8'h00)) u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k),
    .clr_err(clr_err), .q(q), .q_n(q_n), .changed(changed),
    .sr_err(sr_err), .toggle_cnt(toggle_cnt)
  );

  jk_ff_bank #(.WIDTH(8), .CNT_W(2), .RST_VAL(8'h00)) u_sat (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k),
    .clr_err(clr_err), .q(q2), .q_n(q2_n), .changed(changed2),
    .sr_err(sr_err2), .toggle_cnt(toggle_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  // Drive one edge's inputs, queue the model's expectation, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] jj, input logic [7:0] kk, input logic c);
    exp_t       ex;
    logic [7:0] nq;
    logic       ill;
    reset = r; en = e; mode = m; j = jj; k = kk; clr_err = c;
    nq  = mq;
    ill = 1'b0;
    for (int i = 0; i < 8; i++) begin
      unique case (m)
        2'b00: case ({jj[i], kk[i]})
                 2'b01: nq[i] = 1'b0;
                 2'b10: nq[i] = 1'b1;
                 2'b11: nq[i] = ~mq[i];
                 default: ;
               endcase
        2'b01: nq[i] = jj[i];
        2'b10: if (jj[i]) nq[i] = ~mq[i];
        default: case ({jj[i], kk[i]})
                   2'b01: nq[i] = 1'b0;
                   2'b10: nq[i] = 1'b1;
                   2'b11: ill = 1'b1;
                   default: ;
                 endcase
      endcase
    end
    if (r) begin
      ex.q = 8'h00; ex.chg = 1'b0; ex.err = 1'b0; ex.cnt = '0; ex.cnt2 = '0;
    end else begin
      ex.chg = e && (nq != mq);
      ex.q   = e ? nq : mq;
      ex.err = (e && ill) ? 1'b1 : (c ? 1'b0 : merr);
`ifdef JK_FF_BANK_TOGGLE_CNT_EN
      ex.cnt  = (ex.chg && mcnt != 16'hFFFF) ? mcnt + 16'd1 : mcnt;
      ex.cnt2 = (ex.chg && mcnt2 != 2'b11) ? mcnt2 + 2'd1 : mcnt2;
`else
      ex.cnt  = '0;
      ex.cnt2 = '0;
`endif
    end
    mq = ex.q; merr = ex.err; mcnt = ex.cnt; mcnt2 = ex.cnt2;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    chk({tag, ".q"},    {24'd0, q},        {24'd0, ex.q});
    chk({tag, ".q_n"},  {24'd0, q_n},      {24'd0, ~ex.q});
    chk({tag, ".chg"},  {31'd0, changed},  {31'd0, ex.chg});
    chk({tag, ".err"},  {31'd0, sr_err},   {31'd0, ex.err});
    chk({tag, ".cnt"},  {16'd0, toggle_cnt}, {16'd0, ex.cnt});
    chk({tag, ".cnt2"}, {30'd0, toggle_cnt2}, {30'd0, ex.cnt2});
    chk({tag, ".q2"},   {24'd0, q2},       {24'd0, ex.q});
  endtask

  initial begin
    mq = '0; merr = 1'b0; mcnt = '0; mcnt2 = '0;
    reset = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0; clr_err = 1'b0;
    @(negedge clk);

    // Reset, then JK toggle three times
    step("rst",  1, 1, 2'b00, 8'hFF, 8'hFF, 0);
    chk("rst_q", {24'd0, q}, 32'h00);
    step("tg1",  0, 1, 2'b00, 8'hFF, 8'hFF, 0);
    chk("tg1_q", {24'd0, q}, 32'hFF);
    step("tg2",  0, 1, 2'b00, 8'hFF, 8'hFF, 0);
    chk("tg2_q", {24'd0, q}, 32'h00);
    step("tg3",  0, 1, 2'b00, 8'hFF, 8'hFF, 0);
    chk("tg3_q", {24'd0, q}, 32'hFF);
    chk("tg3_chg", {31'd0, changed}, 32'd1);
`ifdef JK_FF_BANK_TOGGLE_CNT_EN
    chk("tg3_cnt", {16'd0, toggle_cnt}, 32'd3);
`else
    chk("tg3_cnt", {16'd0, toggle_cnt}, 32'd0);
`endif

    // Mixed JK set/clear/hold
    step("ldF0", 0, 1, 2'b01, 8'hF0, 8'h00, 0);
    step("jkmx", 0, 1, 2'b00, 8'h0C, 8'h30, 0);
    chk("jkmx_q", {24'd0, q}, 32'hCC);
    step("jkhd", 0, 1, 2'b00, 8'h00, 8'h00, 0);
    chk("jkhd_q", {24'd0, q}, 32'hCC);
    chk("jkhd_chg", {31'd0, changed}, 32'd0);

    // SR mode, error sticky and clear priority
    step("ld00", 0, 1, 2'b01, 8'h00, 8'h00, 0);
    step("sril", 0, 1, 2'b11, 8'h81, 8'h01, 0);
    chk("sril_q", {24'd0, q}, 32'h80);
    chk("sril_err", {31'd0, sr_err}, 32'd1);
    step("srcl", 0, 1, 2'b11, 8'h00, 8'h00, 1);
    chk("srcl_err", {31'd0, sr_err}, 32'd0);
    step("srpr", 0, 1, 2'b11, 8'h02, 8'h02, 1);
    chk("srpr_err", {31'd0, sr_err}, 32'd1);
    step("clren0", 0, 0, 2'b11, 8'hFF, 8'hFF, 1);
    chk("clren0_err", {31'd0, sr_err}, 32'd0);

    // D load, then en=0 hold, then reset overrides en
    step("d5a",  0, 1, 2'b01, 8'h5A, 8'h00, 0);
    step("hold", 0, 0, 2'b01, 8'hFF, 8'h00, 0);
    chk("hold_q", {24'd0, q}, 32'h5A);
    chk("hold_chg", {31'd0, changed}, 32'd0);
    step("rst2", 1, 1, 2'b01, 8'hFF, 8'h00, 0);
    chk("rst2_q", {24'd0, q}, 32'h00);
    chk("rst2_cnt", {16'd0, toggle_cnt}, 32'd0);

    // T mode, five edges, to saturate the 2-bit counter
    for (int i = 0; i < 5; i++) step("tsat", 0, 1, 2'b10, 8'h01, 8'h00, 0);
`ifdef JK_FF_BANK_TOGGLE_CNT_EN
    chk("tsat_cnt2", {30'd0, toggle_cnt2}, 32'd3);
`else
    chk("tsat_cnt2", {30'd0, toggle_cnt2}, 32'd0);
`endif

    // Random mix, with reset now and then
    for (int i = 0; i < 60; i++)
      step("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
